// File: rtl/lbp_pkg.sv
// lbp_pkg: shared types and defaults for the LBP scan scheduler.
package lbp_pkg;
    localparam int DEF_WIDTH = 128;
    typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, BORDER, DONE} state_t;
    typedef enum logic [1:0] {TOP, RIGHT, BOTTOM, LEFT} edge_t;
endpackage

// File: rtl/lbp_scan_sched_if.sv
// lbp_scan_sched_if: engine handshake and result-memory write port of the scan scheduler.
interface lbp_scan_sched_if #(parameter int CW = 7);
    logic gray_ready;
    logic eng_start;
    logic [CW-1:0] eng_row;
    logic [CW-1:0] eng_col;
    logic eng_done;
    logic [7:0] eng_lbp;
    logic [2*CW-1:0] lbp_addr;
    logic [7:0] lbp_data;
    logic lbp_valid;
    logic finish;
    logic busy;
    modport master (
        input  gray_ready, eng_done, eng_lbp,
        output eng_start, eng_row, eng_col, lbp_addr, lbp_data, lbp_valid, finish, busy
    );
    modport slave (
        output gray_ready, eng_done, eng_lbp,
        input  eng_start, eng_row, eng_col, lbp_addr, lbp_data, lbp_valid, finish, busy
    );
endinterface

// File: rtl/lbp_border_gen.sv
// lbp_border_gen: maps (edge, position) to a border pixel address; step marks the end of an edge, last the final border pixel.
module lbp_border_gen
    import lbp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW = $clog2(WIDTH)
) (
    input  edge_t           edge_sel,
    input  logic [CW-1:0]   pos,
    output logic [2*CW-1:0] addr,
    output logic            step,
    output logic            last
);
    localparam logic [CW-1:0] MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] M2 = CW'(WIDTH - 2);
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    // Edge lengths: top W, right W-1, bottom W-1, left W-2 (corners owned by the earlier edge)
    always_comb begin
        row  = edge_sel == TOP ? '0 : edge_sel == RIGHT ? pos + 1'b1 : edge_sel == BOTTOM ? MAX : M2 - pos;
        col  = edge_sel == TOP ? pos : edge_sel == RIGHT ? MAX : edge_sel == BOTTOM ? M2 - pos : '0;
        step = edge_sel == TOP ? pos == MAX : edge_sel == LEFT ? pos == CW'(WIDTH - 3) : pos == M2;
        last = edge_sel == LEFT && step;
    end
    assign addr = {row, col};
endmodule

// File: rtl/lbp_scan_sched.sv
// lbp_scan_sched: walks interior pixels through the LBP engine, then writes a zero border.
module lbp_scan_sched
    import lbp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW = $clog2(WIDTH)
) (
    input logic clk,
    input logic reset,
    lbp_scan_sched_if.master bus
);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] M2 = CW'(WIDTH - 2);
    state_t state, state_nxt;
    edge_t edge_sel;
    logic [CW-1:0] row, col, pos;
    logic [7:0] code;
    logic [2*CW-1:0] b_addr;
    logic b_step, b_last, row_end, last_px;

    assign row_end = col == M2;
    assign last_px = row_end && row == M2;

    lbp_border_gen #(.WIDTH(WIDTH), .CW(CW)) u_border (
        .edge_sel(edge_sel),
        .pos(pos),
        .addr(b_addr),
        .step(b_step),
        .last(b_last)
    );

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.gray_ready ? START : IDLE;
            START:   state_nxt = WAIT;
            WAIT:    state_nxt = bus.eng_done ? WRITE : WAIT;
            WRITE:   state_nxt = last_px ? BORDER : START;
            BORDER:  state_nxt = b_last ? DONE : BORDER;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        bus.eng_start = state == START;
        bus.eng_row   = row;
        bus.eng_col   = col;
        bus.lbp_valid = state == WRITE || state == BORDER;
        bus.lbp_addr  = state == WRITE ? {row, col} : state == BORDER ? b_addr : '0;
        bus.lbp_data  = state == WRITE ? code : '0;
        bus.finish    = state == DONE;
        bus.busy      = state != IDLE;
    end

    always_ff @(posedge clk)
        if (reset) begin
            row      <= ONE;
            col      <= ONE;
            pos      <= '0;
            edge_sel <= TOP;
            code     <= '0;
        end else begin
            if (state == WAIT && bus.eng_done) code <= bus.eng_lbp;
            if (state == WRITE) begin
                if (last_px) begin
                    pos      <= '0;
                    edge_sel <= TOP;
                end else if (row_end) begin
                    col <= ONE;
                    row <= row + 1'b1;
                end else col <= col + 1'b1;
            end
            if (state == BORDER) begin
                pos      <= b_step ? '0 : pos + 1'b1;
                edge_sel <= b_step ? edge_t'(edge_sel + 2'd1) : edge_sel;
            end
            if (state == DONE) begin
                row <= ONE;
                col <= ONE;
            end
        end
endmodule

// File: tb/tb_lbp_scan_sched.sv
// tb_lbp_scan_sched: scoreboard bench; a 128-wide scan with a random-latency engine, directed corner cases, and an 8-wide scan.
module tb_lbp_scan_sched;
    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    lbp_scan_sched_if #(.CW(7)) bus ();
    lbp_scan_sched_if #(.CW(3)) bus8 ();

    lbp_scan_sched #(.WIDTH(128)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    lbp_scan_sched #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.master));

    int vectors = 0, miscompares = 0;
    logic [21:0] exp_q[$];
    logic [21:0] e;
    bit seen[16384];
    bit seen8[64];
    int writes = 0, finishes = 0, writes8 = 0, int8 = 0, finishes8 = 0;
    logic [13:0] last_addr = '0;
    bit stuck = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.lbp_valid) begin
            writes++;
            last_addr = bus.lbp_addr;
            check("dup_addr", 32'(seen[bus.lbp_addr]), 0);
            seen[bus.lbp_addr] = 1;
            if (exp_q.size() == 0) check("extra_write", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.lbp_addr, e[21:8]);
                check("wr_data", bus.lbp_data, e[7:0]);
            end
        end
        if (bus.finish) finishes++;
        if (bus8.lbp_valid) begin
            writes8++;
            check("dup_addr8", 32'(seen8[bus8.lbp_addr]), 0);
            seen8[bus8.lbp_addr] = 1;
            if (bus8.lbp_addr[5:3] inside {[1:6]} && bus8.lbp_addr[2:0] inside {[1:6]}) int8++;
        end
        if (bus8.finish) finishes8++;
    end

    // Answers one engine request at (r,c) after d cycles in WAIT; returns in the WRITE cycle.
    task automatic pixel(int r, int c, int d, logic [7:0] code);
        int n = 0;
        while (!bus.eng_start && n < 100) begin
            tick();
            n++;
        end
        check("start_seen", bus.eng_start, 1);
        if (!bus.eng_start) begin
            stuck = 1;
            return;
        end
        check("eng_row", bus.eng_row, r);
        check("eng_col", bus.eng_col, c);
        repeat (d) tick();
        bus.eng_done = 1;
        bus.eng_lbp = code;
        exp_q.push_back({7'(r), 7'(c), code});
        tick();
        bus.eng_done = 0;
        bus.eng_lbp = 8'($urandom);
        check("wr_latency", bus.lbp_valid, 1);
    endtask

    initial begin
        int n, w0;
        logic prev;
        bus.gray_ready = 0; bus.eng_done = 0; bus.eng_lbp = 0;
        bus8.gray_ready = 0; bus8.eng_done = 0; bus8.eng_lbp = 0;
        repeat (3) tick();
        check("rst_eng_start", bus.eng_start, 0);
        check("rst_valid", bus.lbp_valid, 0);
        check("rst_data", bus.lbp_data, 0);
        check("rst_addr", bus.lbp_addr, 0);
        check("rst_finish", bus.finish, 0);
        check("rst_busy", bus.busy, 0);
        reset = 0;
        bus.gray_ready = 1;
        tick();
        bus.gray_ready = 0;
        check("first_start", bus.eng_start, 1);
        check("first_busy", bus.busy, 1);
        check("first_row", bus.eng_row, 1);
        check("first_col", bus.eng_col, 1);

        for (int r = 1; r <= 126 && !stuck; r++)
            for (int c = 1; c <= 126 && !stuck; c++)
                pixel(r, c, $urandom_range(0, 63) == 0 ? $urandom_range(1, 20) : 1,
                      (r == 1 && c == 1) ? 8'hA5 : 8'($urandom));
        for (int c = 0; c <= 127; c++) exp_q.push_back({7'd0, 7'(c), 8'd0});
        for (int r = 1; r <= 127; r++) exp_q.push_back({7'(r), 7'd127, 8'd0});
        for (int c = 126; c >= 0; c--) exp_q.push_back({7'd127, 7'(c), 8'd0});
        for (int r = 126; r >= 1; r--) exp_q.push_back({7'(r), 7'd0, 8'd0});

        n = 0;
        prev = 1;
        while (!bus.finish && n < 700) begin
            prev = bus.lbp_valid;
            tick();
            n++;
        end
        check("finish_seen", bus.finish, 1);
        check("finish_after_write", prev, 1);
        check("finish_valid_low", bus.lbp_valid, 0);
        check("last_addr", last_addr, 128);
        tick();
        check("finish_one_cycle", bus.finish, 0);
        check("idle_busy", bus.busy, 0);
        check("total_writes", writes, 16384);
        check("queue_drained", exp_q.size(), 0);
        check("finish_count", finishes, 1);

        seen = '{default: 0};
        w0 = writes;
        bus.eng_done = 1;
        tick();
        bus.eng_done = 0;
        tick();
        check("idle_done_busy", bus.busy, 0);
        check("idle_done_writes", writes, w0);
        bus.gray_ready = 1;
        tick();
        bus.gray_ready = 0;
        check("restart_start", bus.eng_start, 1);
        bus.eng_done = 1;
        tick();
        bus.eng_done = 0;
        tick();
        tick();
        check("start_done_ignored", bus.lbp_valid, 0);
        check("wait_hold_busy", bus.busy, 1);
        check("wait_hold_writes", writes, w0);
        reset = 1;
        tick();
        check("midwait_busy", bus.busy, 0);
        check("midwait_start", bus.eng_start, 0);
        check("midwait_valid", bus.lbp_valid, 0);
        check("midwait_addr", bus.lbp_addr, 0);
        check("midwait_data", bus.lbp_data, 0);
        check("midwait_finish", bus.finish, 0);
        reset = 0;
        bus.gray_ready = 1;
        tick();
        bus.gray_ready = 0;
        pixel(1, 1, 3, 8'h3C);
        bus.eng_done = 1;
        tick();
        bus.eng_done = 0;
        pixel(1, 2, 2, 8'h5A);
        tick();
        check("post_reset_writes", writes, w0 + 2);
        check("post_reset_queue", exp_q.size(), 0);
        reset = 1;
        tick();
        reset = 0;

        bus8.gray_ready = 1;
        tick();
        bus8.gray_ready = 0;
        for (int r = 1; r <= 6; r++)
            for (int c = 1; c <= 6; c++) begin
                n = 0;
                while (!bus8.eng_start && n < 100) begin
                    tick();
                    n++;
                end
                check("start8", bus8.eng_start, 1);
                check("row8", bus8.eng_row, r);
                check("col8", bus8.eng_col, c);
                repeat ($urandom_range(1, 20)) tick();
                bus8.eng_done = 1;
                bus8.eng_lbp = 8'($urandom);
                tick();
                bus8.eng_done = 0;
            end
        n = 0;
        while (!bus8.finish && n < 100) begin
            tick();
            n++;
        end
        check("finish8_seen", bus8.finish, 1);
        tick();
        tick();
        check("interior8", int8, 36);
        check("border8", writes8 - int8, 28);
        check("finish8_count", finishes8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lbp_scan_sched.md
LBP_SCAN_SCHED -- requirements
Module: lbp_scan_sched

Interface
REQ-001 Parameter WIDTH, default 128, image side in pixels; a power of two, at least 4.
REQ-002 Parameter CW, default $clog2(WIDTH), coordinate width; the address width is 2*CW (14 at default).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 gray_ready  in  1  image is loaded in gray memory; a scan may start.
REQ-006 eng_start  out  1  one-cycle pulse commanding the LBP engine to process (eng_row, eng_col).
REQ-007 eng_row, eng_col  out  CW each  center coordinate, held stable from eng_start until eng_done is accepted.
REQ-008 eng_done  in  1  engine result valid on eng_lbp this cycle.
REQ-009 eng_lbp  in  8  LBP code from the engine.
REQ-010 lbp_addr  out  2*CW  result memory write address, {row, col}.
REQ-011 lbp_data  out  8  result memory write data.
REQ-012 lbp_valid  out  1  write strobe; exactly one write per high cycle.
REQ-013 finish  out  1  one-cycle pulse when the whole image is written.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT, WRITE, BORDER and DONE, held in a registered state variable.
REQ-016 IDLE: while gray_ready=1, go to START with the coordinate set to (1,1); gray_ready is ignored in all other states.
REQ-017 START: eng_start=1 for exactly this cycle, then go to WAIT.
REQ-018 WAIT: hold until eng_done=1, with no timeout; on eng_done, latch eng_lbp and go to WRITE; eng_done in any other state is ignored.
REQ-019 WRITE: drive lbp_valid=1, lbp_addr={row,col} and lbp_data=latched code; lbp_valid rises exactly 1 cycle after the accepted eng_done.
REQ-020 Interior advance after WRITE:
- If col<WIDTH-2: col+1, next state START.
- If col=WIDTH-2: col=1, row+1, next state START.
- If (row,col)=(WIDTH-2,WIDTH-2): next state BORDER, edge counter cleared.
REQ-021 BORDER: write lbp_data=0 with lbp_valid=1 every cycle, 4*WIDTH-4 writes in this order:
- top row 0, col 0..WIDTH-1;
- right col WIDTH-1, row 1..WIDTH-1;
- bottom row WIDTH-1, col WIDTH-2..0;
- left col 0, row WIDTH-2..1.
REQ-022 The cycle after the last border write, enter DONE: finish=1 and lbp_valid=0 for one cycle, then go to IDLE with the coordinate reset to (1,1).
REQ-023 Outside WRITE and BORDER, lbp_valid=0 and eng_start=0 except in START.
REQ-024 Coordinate arithmetic SHALL be unsigned CW-bit with no wrap below 0 or above WIDTH-1; the address is concatenation, never a multiply.
REQ-025 No pixel address SHALL be written twice in one scan; the scan SHALL produce (WIDTH-2)^2 interior writes plus 4*WIDTH-4 border writes.

Reset
REQ-026 While reset=1, on the clock edge: state=IDLE; coordinate=(1,1); edge counter=0; latched code=0.
REQ-027 Output values during reset: eng_start=0, lbp_valid=0, lbp_data=0, lbp_addr=0, finish=0, busy=0.
REQ-028 Reset in any state, including mid-WAIT or mid-BORDER, SHALL abandon the scan; a new scan restarts at (1,1).

Structure
REQ-029 Package lbp_pkg SHALL hold the state enum type, the default WIDTH and the border edge-select enum (TOP, RIGHT, BOTTOM, LEFT).
REQ-030 One sub-module, lbp_border_gen, SHALL produce border addresses from the edge select and position counter, with step and last-address outputs.

Verification
REQ-031 Reset, then gray_ready=1 at cycle 0 -> START in cycle 1, eng_start=1 with eng_row=1, eng_col=1, busy=1.
REQ-032 eng_done=1, eng_lbp=8'hA5 in WAIT at (1,1) -> next cycle lbp_valid=1, lbp_addr=129, lbp_data=8'hA5; next eng_start at (1,2).
REQ-033 Complete (1,126), addr 254 -> next eng_start at (2,1); complete (126,126), addr 16254 -> first border write addr 0, data 0.
REQ-034 Full scan at WIDTH=128 with an engine answering after a random 1-20 cycles -> 15876 interior plus 508 border writes, last write addr 128, finish pulse one cycle later, every address written exactly once.
REQ-035 eng_done pulsed in IDLE, START and WRITE -> no extra writes; reset asserted mid-WAIT -> next cycle IDLE, all outputs 0; next scan starts at (1,1).
REQ-036 WIDTH=8 -> 36 interior writes, 28 border writes, finish exactly once.
